// File: rtl/sal_ddr_pkg.sv
// Shared DRAM bank-controller types: address widths, bank/bank-group widths,
// page-policy encoding and the per-bank state machine encoding.
package sal_ddr_pkg;

  localparam int DRAM_RA_W = 16;
  localparam int DRAM_CA_W = 10;
  localparam int BA_W      = 2;
  localparam int BG_W      = 2;

  typedef logic [DRAM_RA_W-1:0] dram_ra_t;
  typedef logic [DRAM_CA_W-1:0] dram_ca_t;
  typedef logic [BA_W-1:0]      dram_ba_t;
  typedef logic [BG_W-1:0]      dram_bg_t;

  typedef enum logic [1:0] {
    PP_OPEN    = 2'd0,
    PP_CLOSE   = 2'd1,
    PP_TIMEOUT = 2'd2
  } page_policy_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVATING,
    ST_BANK_ACTIVE,
    ST_READING,
    ST_WRITING,
    ST_AUTO_PRE,
    ST_PRECHARGING,
    ST_REFRESHING
  } bk_state_e;

endpackage

// File: rtl/TIMING_IF.sv
// Bank timing parameters, programmed by the channel and read by every bank controller.
interface TIMING_IF #(parameter int CNT_W = 6) ();
  logic [CNT_W-1:0] t_rcd_m2;
  logic [CNT_W-1:0] t_rp_m2;
  logic [CNT_W-1:0] t_rfc_m2;
  logic [CNT_W-1:0] burst_cycle_m2;
  logic [CNT_W-1:0] t_rc_m1;
  logic [CNT_W-1:0] t_ras_m1;
  logic [CNT_W-1:0] t_rtp_m1;
  logic [CNT_W-1:0] t_wtp_m1;
  logic [CNT_W-1:0] row_open_cnt;

  modport MON (
    input t_rcd_m2, t_rp_m2, t_rfc_m2, burst_cycle_m2,
          t_rc_m1, t_ras_m1, t_rtp_m1, t_wtp_m1, row_open_cnt
  );
endinterface

// File: rtl/sal_timing_cntr.sv
// Reloadable down-counter that saturates at zero; a reload in the same cycle
// as zero takes priority, and "met" is simply the register being zero.
module sal_timing_cntr #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reset_cmd_i,
  input  logic [CNT_W-1:0] reset_value_i,
  output logic             is_zero_o
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (reset_cmd_i) begin
      cnt <= reset_value_i;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign is_zero_o = (cnt == '0);

endmodule

// File: rtl/sal_bk_ctrl_pp.sv
// Per-bank DRAM command generator: ACT/RD/WR/PRE/REF request arbitration with
// open/close/timeout page policy, urgent-refresh preemption and bank-local timing.
module sal_bk_ctrl_pp
  import sal_ddr_pkg::*;
#(
  parameter int BK_ID       = 0,
  parameter int BG_ID       = 0,
  parameter int RA_W        = 16,
  parameter int CA_W        = 10,
  parameter int ID_W        = 4,
  parameter int LEN_W       = 4,
  parameter int CNT_W       = 6,
  parameter int PAGE_POLICY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  TIMING_IF.MON            timing_if,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_wr_i,
  input  logic [RA_W-1:0]  req_ra_i,
  input  logic [CA_W-1:0]  req_ca_i,
  input  logic [ID_W-1:0]  req_id_i,
  input  logic [LEN_W-1:0] req_len_i,
  output logic             act_req_o,
  output logic             rd_req_o,
  output logic             wr_req_o,
  output logic             pre_req_o,
  output logic             ref_req_o,
  input  logic             act_gnt_i,
  input  logic             rd_gnt_i,
  input  logic             wr_gnt_i,
  input  logic             pre_gnt_i,
  input  logic             ref_gnt_i,
  output logic             ap_o,
  output dram_ba_t         ba_o,
  output dram_bg_t         bg_o,
  output logic [RA_W-1:0]  ra_o,
  output logic [CA_W-1:0]  ca_o,
  output logic [ID_W-1:0]  id_o,
  output logic [LEN_W-1:0] len_o,
  input  logic             ref_req_i,
  input  logic             ref_urgent_i,
  output logic             ref_gnt_o,
  output logic             row_open_o,
  output logic [RA_W-1:0]  open_ra_o
);

  localparam logic AP_POL = (PAGE_POLICY == int'(PP_CLOSE));
  localparam logic TO_POL = (PAGE_POLICY == int'(PP_TIMEOUT));

  bk_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [RA_W-1:0]  open_ra;
  logic             ap_q;
  logic             act_gnt, rd_gnt, wr_gnt;
  logic             trc_met, tras_met, trtp_met, twtp_met, ro_zero;
  logic             pre_ok, row_hit, ref_cond;

  assign act_gnt  = act_gnt_i & act_req_o;
  assign rd_gnt   = rd_gnt_i & rd_req_o;
  assign wr_gnt   = wr_gnt_i & wr_req_o;
  assign pre_ok   = tras_met & trtp_met & twtp_met;
  assign row_hit  = (req_ra_i == open_ra);
  assign ref_cond = ref_urgent_i | (ref_req_i & ~req_valid_i);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      open_ra <= '0;
      ap_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (act_gnt) open_ra <= req_ra_i;
      if (rd_gnt | wr_gnt) ap_q <= AP_POL;
    end
  end

  // Requests are gated by rst_n so nothing is offered in a reset cycle.
  always_comb begin
    act_req_o = 1'b0;
    rd_req_o  = 1'b0;
    wr_req_o  = 1'b0;
    pre_req_o = 1'b0;
    ref_req_o = 1'b0;
    state_nxt = state;
    cnt_nxt   = (cnt != '0) ? cnt - 1'b1 : '0;
    unique case (state)
      ST_IDLE: begin
        if (rst_n && trc_met) begin
          if (ref_cond)         ref_req_o = 1'b1;
          else if (req_valid_i) act_req_o = 1'b1;
        end
        if (ref_req_o && ref_gnt_i) begin
          state_nxt = ST_REFRESHING;
          cnt_nxt   = timing_if.t_rfc_m2;
        end else if (act_req_o && act_gnt_i) begin
          state_nxt = ST_ACTIVATING;
          cnt_nxt   = timing_if.t_rcd_m2;
        end
      end
      ST_ACTIVATING: if (cnt == '0) state_nxt = ST_BANK_ACTIVE;
      ST_BANK_ACTIVE: begin
        if (rst_n) begin
          if (ref_urgent_i) begin
            pre_req_o = pre_ok;
          end else if (req_valid_i) begin
            if (row_hit) begin
              rd_req_o = ~req_wr_i;
              wr_req_o = req_wr_i;
            end else begin
              pre_req_o = pre_ok;
            end
          end else if (TO_POL) begin
            pre_req_o = pre_ok & ro_zero;
          end
        end
        if (rd_req_o && rd_gnt_i) begin
          state_nxt = ST_READING;
          cnt_nxt   = timing_if.burst_cycle_m2;
        end else if (wr_req_o && wr_gnt_i) begin
          state_nxt = ST_WRITING;
          cnt_nxt   = timing_if.burst_cycle_m2;
        end else if (pre_req_o && pre_gnt_i) begin
          state_nxt = ST_PRECHARGING;
          cnt_nxt   = timing_if.t_rp_m2;
        end
      end
      ST_READING, ST_WRITING: begin
        if (cnt == '0) state_nxt = ap_q ? ST_AUTO_PRE : ST_BANK_ACTIVE;
      end
      ST_AUTO_PRE: begin
        if (pre_ok) begin
          state_nxt = ST_PRECHARGING;
          cnt_nxt   = timing_if.t_rp_m2;
        end
      end
      ST_PRECHARGING, ST_REFRESHING: if (cnt == '0) state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ra_o  = '0;
    ca_o  = '0;
    id_o  = '0;
    len_o = '0;
    ap_o  = 1'b0;
    if (act_req_o) ra_o = req_ra_i;
    if (pre_req_o) ra_o = open_ra;
    if (rd_req_o || wr_req_o) begin
      ra_o  = open_ra;
      ca_o  = req_ca_i;
      id_o  = req_id_i;
      len_o = req_len_i;
      ap_o  = AP_POL;
    end
  end

  assign req_ready_o = rd_gnt | wr_gnt;
  assign ref_gnt_o   = ref_req_o & ref_gnt_i;
  assign row_open_o  = (state == ST_ACTIVATING) || (state == ST_BANK_ACTIVE) ||
                       (state == ST_READING)    || (state == ST_WRITING);
  assign open_ra_o   = open_ra;
  assign ba_o        = dram_ba_t'(BK_ID);
  assign bg_o        = dram_bg_t'(BG_ID);

  sal_timing_cntr #(.CNT_W(CNT_W)) u_trc (
    .clk(clk), .rst_n(rst_n), .reset_cmd_i(act_gnt),
    .reset_value_i(timing_if.t_rc_m1), .is_zero_o(trc_met));
  sal_timing_cntr #(.CNT_W(CNT_W)) u_tras (
    .clk(clk), .rst_n(rst_n), .reset_cmd_i(act_gnt),
    .reset_value_i(timing_if.t_ras_m1), .is_zero_o(tras_met));
  sal_timing_cntr #(.CNT_W(CNT_W)) u_trtp (
    .clk(clk), .rst_n(rst_n), .reset_cmd_i(rd_gnt),
    .reset_value_i(timing_if.t_rtp_m1), .is_zero_o(trtp_met));
  sal_timing_cntr #(.CNT_W(CNT_W)) u_twtp (
    .clk(clk), .rst_n(rst_n), .reset_cmd_i(wr_gnt),
    .reset_value_i(timing_if.t_wtp_m1), .is_zero_o(twtp_met));
  sal_timing_cntr #(.CNT_W(CNT_W)) u_row_open (
    .clk(clk), .rst_n(rst_n), .reset_cmd_i(rd_gnt | wr_gnt),
    .reset_value_i(timing_if.row_open_cnt), .is_zero_o(ro_zero));

endmodule

// File: tb/tb_sal_bk_ctrl_pp.sv
// Directed bench: one controller per page policy, each with a scheduler that
// grants whatever it is offered in the same cycle.
module tb_sal_bk_ctrl_pp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_wr, ref_req, ref_urg;
  logic [15:0] req_ra;
  logic [9:0]  req_ca;
  logic [3:0]  req_id, req_len;
  int          sel;

  logic        act_req [3], rd_req [3], wr_req [3], pre_req [3], ref_rq [3];
  logic        req_ready [3], ap [3], ref_gnt [3], row_open [3];
  logic [1:0]  ba [3], bg [3];
  logic [15:0] ra [3], open_ra [3];
  logic [9:0]  ca [3];
  logic [3:0]  id [3], len [3];
  int          pre_cnt [3];

  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;
  int t_act, t_rd, t_rd2, t_wr, t_pre, t_ref, t_act2, pre_snap;

  always #5 clk = ~clk;

  TIMING_IF #(.CNT_W(6)) tif ();

  for (genvar p = 0; p < 3; p++) begin : g_dut
    sal_bk_ctrl_pp #(.BK_ID(p + 1), .BG_ID(2), .PAGE_POLICY(p)) u_dut (
      .clk(clk), .rst_n(rst_n), .timing_if(tif),
      .req_valid_i(req_valid && (sel == p)), .req_ready_o(req_ready[p]),
      .req_wr_i(req_wr), .req_ra_i(req_ra), .req_ca_i(req_ca),
      .req_id_i(req_id), .req_len_i(req_len),
      .act_req_o(act_req[p]), .rd_req_o(rd_req[p]), .wr_req_o(wr_req[p]),
      .pre_req_o(pre_req[p]), .ref_req_o(ref_rq[p]),
      .act_gnt_i(act_req[p]), .rd_gnt_i(rd_req[p]), .wr_gnt_i(wr_req[p]),
      .pre_gnt_i(pre_req[p]), .ref_gnt_i(ref_rq[p]),
      .ap_o(ap[p]), .ba_o(ba[p]), .bg_o(bg[p]),
      .ra_o(ra[p]), .ca_o(ca[p]), .id_o(id[p]), .len_o(len[p]),
      .ref_req_i(ref_req), .ref_urgent_i(ref_urg), .ref_gnt_o(ref_gnt[p]),
      .row_open_o(row_open[p]), .open_ra_o(open_ra[p]));
  end

  always @(posedge clk) begin
    for (int p = 0; p < 3; p++) if (pre_req[p]) pre_cnt[p] <= pre_cnt[p] + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig_of(input int k);
    case (k)
      0:       return act_req[sel];
      1:       return rd_req[sel];
      2:       return wr_req[sel];
      3:       return pre_req[sel];
      default: return ref_rq[sel];
    endcase
  endfunction

  task automatic wait_sig(input int k, input int budget, output int at);
    at = -1000;
    for (int i = 0; i < budget; i++) begin
      if (sig_of(k)) begin
        at = cyc_n;
        return;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    ref_req = 1'b0;
    ref_urg = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    tif.t_rcd_m2 = 6'd2;  tif.t_rp_m2 = 6'd1;  tif.t_rfc_m2 = 6'd4;
    tif.burst_cycle_m2 = 6'd2;  tif.t_rc_m1 = 6'd3;  tif.t_ras_m1 = 6'd3;
    tif.t_rtp_m1 = 6'd1;  tif.t_wtp_m1 = 6'd3;  tif.row_open_cnt = 6'd5;
    sel = 0;
    rst_n = 1'b0;  ref_req = 1'b0;  ref_urg = 1'b0;
    req_valid = 1'b1;  req_wr = 1'b0;  req_ra = 16'h12;
    req_ca = 10'h5;  req_id = 4'h3;  req_len = 4'h7;
    pre_snap = 0;

    // Reset with a request pending: nothing offered, fields zero.
    tick(); tick();
    chk("rst_act", act_req[0], 1'b0);
    chk("rst_ra", ra[0], 16'h0);
    chk("rst_row_open", row_open[0], 1'b0);
    chk("rst_ready", req_ready[0], 1'b0);
    chk("rst_ref_gnt", ref_gnt[0], 1'b0);
    chk("rst_ap", ap[0], 1'b0);
    chk("ba_const", ba[0], 2'd1);
    chk("bg_const", bg[0], 2'd2);

    // Open page: ACT, RD 4 cycles later, hit RD 4 cycles after that, row held.
    pre_snap = pre_cnt[0];
    rst_n = 1'b1; #1;
    chk("t1_act", act_req[0], 1'b1);
    chk("t1_act_ra", ra[0], 16'h12);
    t_act = cyc_n;
    tick();
    wait_sig(1, 10, t_rd);
    chk("t1_rd_lat", t_rd - t_act, 4);
    chk("t1_rd_ca", ca[0], 10'h5);
    chk("t1_rd_id", id[0], 4'h3);
    chk("t1_rd_len", len[0], 4'h7);
    chk("t1_rd_ap", ap[0], 1'b0);
    chk("t1_ready", req_ready[0], 1'b1);
    tick();
    req_ca = 10'h6; #1;
    chk("t1_ready_low", req_ready[0], 1'b0);
    wait_sig(1, 10, t_rd2);
    chk("t1_rd2_lat", t_rd2 - t_rd, 4);
    chk("t1_rd2_ca", ca[0], 10'h6);
    tick();
    req_valid = 1'b0;
    repeat (10) tick();
    chk("t1_row_held", row_open[0], 1'b1);
    chk("t1_idle_ra", ra[0], 16'h0);
    chk("t1_no_pre", pre_cnt[0] - pre_snap, 0);

    // Row miss: PRE waits for tRAS (10 cycles after ACT), then ACT after tRP.
    tif.t_ras_m1 = 6'd9;  tif.t_rc_m1 = 6'd10;
    do_reset();
    req_valid = 1'b1;  req_ra = 16'h12; #1;
    wait_sig(0, 5, t_act);
    tick();
    wait_sig(1, 10, t_rd);
    tick();
    req_ra = 16'h34; #1;
    repeat (3) tick();
    chk("t2_miss_no_rd", rd_req[0], 1'b0);
    chk("t2_early_pre", pre_req[0], 1'b0);
    wait_sig(3, 20, t_pre);
    chk("t2_pre_lat", t_pre - t_act, 10);
    tick();
    wait_sig(0, 10, t_act2);
    chk("t2_act2_lat", t_act2 - t_pre, 3);
    chk("t2_act2_ra", ra[0], 16'h34);

    // Close page: WR with auto-precharge, AUTO_PRE until tWTP, no explicit PRE.
    tif.t_ras_m1 = 6'd3;  tif.t_rc_m1 = 6'd3;  tif.t_wtp_m1 = 6'd6;
    sel = 1;
    do_reset();
    pre_snap = pre_cnt[1];
    req_valid = 1'b1;  req_wr = 1'b1;  req_ra = 16'h20;  req_ca = 10'h9; #1;
    wait_sig(0, 5, t_act);
    tick();
    wait_sig(2, 10, t_wr);
    chk("t3_wr_lat", t_wr - t_act, 4);
    chk("t3_wr_ap", ap[1], 1'b1);
    chk("t3_wr_ca", ca[1], 10'h9);
    chk("t3_ready", req_ready[1], 1'b1);
    tick();
    req_valid = 1'b0;
    tick(); tick();
    chk("t3_writing_open", row_open[1], 1'b1);
    tick();
    chk("t3_autopre_closed", row_open[1], 1'b0);
    req_valid = 1'b1;  req_wr = 1'b0;  req_ra = 16'h21; #1;
    wait_sig(0, 15, t_act2);
    chk("t3_idle_lat", t_act2 - t_wr, 10);
    chk("t3_no_pre", pre_cnt[1] - pre_snap, 0);

    // Timeout page: PRE 6 cycles after RD when idle.
    tif.t_wtp_m1 = 6'd3;
    sel = 2;
    do_reset();
    req_valid = 1'b1;  req_ra = 16'h40; #1;
    wait_sig(0, 5, t_act);
    tick();
    wait_sig(1, 10, t_rd);
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    chk("t4_pre_early", pre_req[2], 1'b0);
    chk("t4_row_open", row_open[2], 1'b1);
    tick();
    chk("t4_pre_timeout", pre_req[2], 1'b1);
    chk("t4_pre_lat", cyc_n - t_rd, 6);

    // Timeout page: a request arriving before expiry is a hit.
    do_reset();
    req_valid = 1'b1;  req_ra = 16'h40; #1;
    wait_sig(0, 5, t_act);
    tick();
    wait_sig(1, 10, t_rd);
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    req_valid = 1'b1;  req_ca = 10'h2; #1;
    chk("t4_hit_rd", rd_req[2], 1'b1);
    chk("t4_hit_no_pre", pre_req[2], 1'b0);
    chk("t4_hit_ap", ap[2], 1'b0);

    // Urgent refresh preempts a hit stream.
    tif.t_ras_m1 = 6'd9;  tif.t_rc_m1 = 6'd3;
    sel = 0;
    do_reset();
    req_valid = 1'b1;  req_ra = 16'h55; #1;
    wait_sig(0, 5, t_act);
    tick();
    wait_sig(1, 10, t_rd);
    chk("t5_rd_lat", t_rd - t_act, 4);
    repeat (3) tick();
    ref_urg = 1'b1; #1;
    tick();
    chk("t5_rd_blocked", rd_req[0], 1'b0);
    chk("t5_pre_wait", pre_req[0], 1'b0);
    wait_sig(3, 10, t_pre);
    chk("t5_pre_lat", t_pre - t_act, 10);
    tick();
    wait_sig(4, 10, t_ref);
    chk("t5_ref_lat", t_ref - t_pre, 3);
    chk("t5_ref_gnt", ref_gnt[0], 1'b1);
    chk("t5_ref_no_act", act_req[0], 1'b0);
    tick();
    ref_urg = 1'b0; #1;
    chk("t5_ref_gnt_pulse", ref_gnt[0], 1'b0);
    wait_sig(0, 10, t_act2);
    chk("t5_rfc_lat", t_act2 - t_ref, 6);

    // Reset while READING with the request still pending.
    tif.t_ras_m1 = 6'd3;
    do_reset();
    req_valid = 1'b1;  req_ra = 16'h66; #1;
    wait_sig(0, 5, t_act);
    tick();
    wait_sig(1, 10, t_rd);
    tick();
    rst_n = 1'b0; #1;
    tick();
    chk("t6_act", act_req[0], 1'b0);
    chk("t6_rd", rd_req[0], 1'b0);
    chk("t6_row_open", row_open[0], 1'b0);
    chk("t6_ready", req_ready[0], 1'b0);
    chk("t6_ra", ra[0], 16'h0);
    rst_n = 1'b1; #1;
    chk("t6_fresh_act", act_req[0], 1'b1);
    chk("t6_fresh_ra", ra[0], 16'h66);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
